// File: rtl/gaussian_frame_ctrl.sv
// Frame sequencer for a streaming Gaussian datapath: clear, run, flush, done.
// Optional statistics outputs are enabled with GAUSS_CTRL_STATS_EN.
module gaussian_frame_ctrl #(
  parameter int IMG_W   = 400,
  parameter int IMG_H   = 300,
  parameter int LAT     = 804,
  parameter int CLR_CYC = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  output logic        o_dp_clk_en,
  output logic        o_dp_reset,
  output logic        o_dp_din_sel,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic        o_out_sof,
  output logic        o_out_eol,
  output logic        o_out_eof
`ifdef GAUSS_CTRL_STATS_EN
  ,
  output logic [15:0] o_frame_cnt,
  output logic [31:0] o_stall_cnt
`endif
);

  localparam int N   = IMG_W * IMG_H;
  localparam int SW  = $clog2(N + LAT + 1);
  localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW  = $clog2(IMG_H + 1);
  localparam int CCW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, FLUSH, DONE} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [SW-1:0]   r_stepCnt;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [CCW-1:0]  r_clrCnt;
  logic            w_emit;
  logic            w_cand;
  logic            w_step;
  logic            w_lastIn;
  logic            w_lastOut;

  always_comb begin
    w_nextState = r_state;
    w_emit      = (r_stepCnt >= SW'(LAT));
    w_cand      = ((r_state == RUN) && i_in_valid) || (r_state == FLUSH);
    w_step      = w_cand && (i_out_ready || !w_emit);
    w_lastIn    = (r_stepCnt == SW'(N - 1));
    w_lastOut   = (r_stepCnt == SW'(N + LAT - 1));

    case (r_state)
      IDLE:  if (i_start) w_nextState = CLEAR;
      CLEAR: if (r_clrCnt == CCW'(CLR_CYC - 1)) w_nextState = RUN;
      // With zero latency the last input step is also the last output step.
      RUN:   if (w_step && w_lastIn) w_nextState = (LAT == 0) ? DONE : FLUSH;
      FLUSH: if (w_step && w_lastOut) w_nextState = DONE;
      DONE:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase

    o_busy       = (r_state != IDLE);
    o_done       = (r_state == DONE);
    o_in_ready   = (r_state == RUN) && (i_out_ready || !w_emit);
    o_dp_clk_en  = (r_state == CLEAR) || w_step;
    o_dp_reset   = (r_state == CLEAR);
    o_dp_din_sel = (r_state == FLUSH);
    o_out_valid  = w_cand && w_emit;
    o_out_sof    = o_out_valid && (r_stepCnt == SW'(LAT));
    o_out_eol    = o_out_valid && (r_col == CW'(IMG_W - 1));
    o_out_eof    = o_out_eol && (r_row == RW'(IMG_H - 1));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_stepCnt <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_clrCnt  <= '0;
    end else begin
      r_state <= w_nextState;
      if ((r_state == IDLE) && i_start) begin
        r_stepCnt <= '0;
        r_col     <= '0;
        r_row     <= '0;
        r_clrCnt  <= '0;
      end
      if (r_state == CLEAR) r_clrCnt <= r_clrCnt + 1'b1;
      if (w_step) begin
        r_stepCnt <= r_stepCnt + 1'b1;
        if (w_emit) begin
          if (r_col == CW'(IMG_W - 1)) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
      end
    end
  end

`ifdef GAUSS_CTRL_STATS_EN
  // Stall counter saturates rather than wrapping so long stalls stay visible.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_frame_cnt <= '0;
      o_stall_cnt <= '0;
    end else begin
      if (r_state == DONE) o_frame_cnt <= o_frame_cnt + 1'b1;
      if (w_cand && !w_step && (o_stall_cnt != '1)) o_stall_cnt <= o_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/gaussian_frame_ctrl.md
GAUSSIAN_FRAME_CTRL -- requirements
Module: gaussian_frame_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 400, pixels per line.
REQ-002 SHALL have parameter IMG_H, default 300, lines per frame; N = IMG_W*IMG_H.
REQ-003 SHALL have parameter LAT, default 804, datapath steps from first input pixel to first valid output pixel.
REQ-004 SHALL have parameter CLR_CYC, default 4, datapath clear cycles.
REQ-005 Clk  in  1  sole clock; all logic on posedge Clk.
REQ-006 Reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  begin one frame; sampled only in IDLE.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse at end of frame.
REQ-010 in_valid / in_ready  in / out  1 / 1  source pixel handshake.
REQ-011 dp_clk_en  out  1  datapath clock enable (one step per high cycle).
REQ-012 dp_reset  out  1  datapath synchronous clear.
REQ-013 dp_din_sel  out  1  0 = source pixel into datapath, 1 = zero pixel (flush).
REQ-014 out_valid / out_ready  out / in  1 / 1  sink handshake for datapath output.
REQ-015 out_sof, out_eol, out_eof  out  1 each  first pixel, last pixel of line, last pixel of frame; qualified by out_valid.

Function
REQ-016 States SHALL be IDLE, CLEAR, RUN, FLUSH, DONE.
REQ-017 IDLE: start=1 -> CLEAR; step counter (0..N+LAT-1) and output row/col counters cleared.
REQ-018 CLEAR: dp_reset=1 and dp_clk_en=1 for exactly CLR_CYC cycles, then RUN; in_ready=0.
REQ-019 cand = (RUN & in_valid) | FLUSH; emit = (step_cnt >= LAT).
REQ-020 step = cand & (out_ready | ~emit); dp_clk_en = step outside CLEAR.
REQ-021 in_ready = RUN & (out_ready | ~emit); combinational, no dependency on in_valid.
REQ-022 out_valid = cand & emit, combinational, independent of out_ready (datapath output is combinational from din).
REQ-023 step_cnt SHALL increment by 1 on every step.
REQ-024 RUN -> FLUSH on the step where step_cnt = N-1; dp_din_sel=1 only in FLUSH.
REQ-025 FLUSH -> DONE on the step where step_cnt = N+LAT-1; DONE lasts one cycle, done=1, then IDLE.
REQ-026 Output index = step_cnt-LAT; out_sof when index=0, out_eol when output col = IMG_W-1, out_eof when index = N-1; col wraps to 0 and row increments on out_eol.
REQ-027 Exactly N out_valid&out_ready transfers SHALL occur per frame.
REQ-028 in_valid=0 in RUN: no step, out_valid=0, counters hold.
REQ-029 out_ready=0 while emit: no step, in_ready=0, all counters and state hold.
REQ-030 start outside IDLE, including in DONE, SHALL be ignored.
REQ-031 LAT=0: out_valid SHALL accompany the first accepted pixel; FLUSH lasts zero steps (RUN -> DONE directly).

Reset
REQ-032 Reset=1 SHALL immediately force IDLE, clear all counters, and drive busy, done, in_ready, dp_clk_en, dp_din_sel, out_valid, out_sof, out_eol, out_eof to 0; dp_reset to 0.
REQ-033 Reset mid-frame SHALL abort the frame without a done pulse; the next start runs a full CLEAR.

Configuration
REQ-034 With GAUSS_CTRL_STATS_EN defined SHALL add outputs frame_cnt[15:0] (increments on done, wraps) and stall_cnt[31:0] (increments each cycle cand & ~step, saturates at max), both cleared by Reset.
REQ-035 Without GAUSS_CTRL_STATS_EN these ports and their registers SHALL be absent; all other behaviour identical.

Verification (IMG_W=4, IMG_H=3, LAT=5, CLR_CYC=2)
REQ-036 start pulse, in_valid=1, out_ready=1 -> dp_reset high 2 cycles, 12 RUN steps then 5 FLUSH steps, out_valid from 6th step, 12 outputs, out_eol on outputs 4/8/12, out_eof with 17th step, done next cycle.
REQ-037 out_ready=0 for 3 cycles after 2nd output -> in_ready=0, dp_clk_en=0, counters frozen, no lost or duplicated output; stall_cnt=3 with macro.
REQ-038 in_valid toggling 1,0 during RUN -> steps only on in_valid=1 cycles, out_valid=0 on gap cycles, total outputs still 12.
REQ-039 Reset asserted mid-RUN between clock edges -> outputs 0 before next edge, state IDLE, no done; following start yields full 12-output frame.
REQ-040 start held high through entire frame -> single frame only while busy; second frame begins the cycle after return to IDLE; frame_cnt=2 after both.
